// File: rtl/q_mem_pkg.sv
// Shared constants and helpers for the Q-table memory interface.
// Derived localparams reflect the default build; helpers take the widths they need as arguments.
package q_mem_pkg;

  localparam int DEF_S_WIDTH    = 12;
  localparam int DEF_A_WIDTH    = 2;
  localparam int DEF_Q_WIDTH    = 16;
  localparam int N_ACT          = 2 ** DEF_A_WIDTH;
  localparam int WORD_W         = DEF_Q_WIDTH * N_ACT;
  localparam int BE_W           = WORD_W / 8;
  localparam int BYTES_PER_WORD = BE_W;

  // Widest byte-enable mask the helper can produce; callers truncate to their own width.
  localparam int MAX_BE = 256;

  function automatic logic [MAX_BE-1:0] lane_be(input int act, input int lane_bytes);
    logic [MAX_BE-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_BE; i++) begin
      mask[i] = (i >= act * lane_bytes) && (i < (act + 1) * lane_bytes);
    end
    return mask;
  endfunction

  function automatic logic [63:0] state_addr(input logic [63:0] state,
                                             input logic [63:0] base,
                                             input logic [63:0] bytes_per_word);
    return base + state * bytes_per_word;
  endfunction

endpackage

// File: rtl/act_delay_line.sv
// Generic valid+data shift register with a fixed depth and no stall.
module act_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      data_q[0]  <= in_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/q_mem_if.sv
// Q-table memory interface: state-to-address mapping, BRAM read/write issue and action delay line.
// Define Q_BYPASS_EN to forward writes that race an in-flight read into the returned Q vector.
module q_mem_if
  import q_mem_pkg::*;
#(
  parameter int                    S_WIDTH    = DEF_S_WIDTH,
  parameter int                    A_WIDTH    = DEF_A_WIDTH,
  parameter int                    Q_WIDTH    = DEF_Q_WIDTH,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter int                    PIPE_DEPTH = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rd_valid,
  input  logic [S_WIDTH-1:0]                    rd_state,
  output logic [ADDR_WIDTH-1:0]                 rd_addr,
  output logic                                  rd_en,
  input  logic [Q_WIDTH*(2**A_WIDTH)-1:0]       rd_data,
  output logic                                  q_vec_valid,
  output logic [Q_WIDTH*(2**A_WIDTH)-1:0]       q_vec,
  input  logic                                  wr_valid,
  input  logic [S_WIDTH-1:0]                    wr_state,
  input  logic [A_WIDTH-1:0]                    wr_act,
  input  logic [Q_WIDTH-1:0]                    wr_q,
  output logic [ADDR_WIDTH-1:0]                 wr_addr,
  output logic [Q_WIDTH*(2**A_WIDTH)-1:0]       wr_data,
  output logic [Q_WIDTH*(2**A_WIDTH)/8-1:0]     wr_be,
  input  logic                                  act_valid,
  input  logic [A_WIDTH-1:0]                    act_in,
  output logic                                  act_dly_valid,
  output logic [A_WIDTH-1:0]                    act_dly
);

  localparam int LANES      = 2 ** A_WIDTH;
  localparam int WORD_BITS  = Q_WIDTH * LANES;
  localparam int BE_BITS    = WORD_BITS / 8;
  localparam int WORD_BYTES = BE_BITS;
  localparam int LANE_BYTES = Q_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q;
  logic                  q_vec_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [Q_WIDTH-1:0]    wr_q_q, wr_q_d;
  logic [BE_BITS-1:0]    wr_be_q, wr_be_d;
  logic [WORD_BITS-1:0]  merged;

  always_comb begin
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_q_d    = wr_q_q;
    wr_be_d   = '0;
    if (rd_valid) begin
      rd_addr_d = ADDR_WIDTH'(state_addr(64'(rd_state), 64'(ADDR_BASE), 64'(WORD_BYTES)));
    end
    if (wr_valid) begin
      wr_addr_d = ADDR_WIDTH'(state_addr(64'(wr_state), 64'(ADDR_BASE), 64'(WORD_BYTES)));
      wr_q_d    = wr_q;
      wr_be_d   = BE_BITS'(lane_be(32'(wr_act), LANE_BYTES));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q     <= '0;
      rd_en_q       <= 1'b0;
      q_vec_valid_q <= 1'b0;
      wr_addr_q     <= '0;
      wr_q_q        <= '0;
      wr_be_q       <= '0;
    end else begin
      rd_addr_q     <= rd_addr_d;
      rd_en_q       <= rd_valid;
      q_vec_valid_q <= rd_en_q;
      wr_addr_q     <= wr_addr_d;
      wr_q_q        <= wr_q_d;
      wr_be_q       <= wr_be_d;
    end
  end

`ifdef Q_BYPASS_EN
  // Port A is read-first, so a write issued alongside rd_en is captured here and a write
  // issued in the return cycle is taken straight from the port B registers below.
  logic [ADDR_WIDTH-1:0] infl_addr_q;
  logic [LANES-1:0]      pend_mask_q;
  logic [Q_WIDTH-1:0]    pend_val_q;
  logic [A_WIDTH-1:0]    wr_act_q;
  logic                  wr_en;
  logic                  early_hit;
  logic                  late_hit;

  assign wr_en     = |wr_be_q;
  assign early_hit = rd_en_q && wr_en && (wr_addr_q == rd_addr_q);
  assign late_hit  = q_vec_valid_q && wr_en && (wr_addr_q == infl_addr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_addr_q <= '0;
      pend_mask_q <= '0;
      pend_val_q  <= '0;
      wr_act_q    <= '0;
    end else begin
      if (wr_valid) begin
        wr_act_q <= wr_act;
      end
      if (rd_en_q) begin
        infl_addr_q <= rd_addr_q;
        pend_val_q  <= wr_q_q;
        pend_mask_q <= early_hit ? (LANES'(1) << wr_act_q) : '0;
      end else begin
        pend_mask_q <= '0;
      end
    end
  end

  // The return-cycle write is newer than the captured one, so it is applied last.
  always_comb begin
    merged = rd_data;
    for (int a = 0; a < LANES; a++) begin
      if (pend_mask_q[a]) begin
        merged[a*Q_WIDTH +: Q_WIDTH] = pend_val_q;
      end
      if (late_hit && (wr_act_q == A_WIDTH'(a))) begin
        merged[a*Q_WIDTH +: Q_WIDTH] = wr_q_q;
      end
    end
  end
`else
  always_comb begin
    merged = rd_data;
  end
`endif

  act_delay_line #(
    .WIDTH(A_WIDTH),
    .DEPTH(PIPE_DEPTH)
  ) u_act_delay_line (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (act_valid),
    .in_data_i  (act_in),
    .out_valid_o(act_dly_valid),
    .out_data_o (act_dly)
  );

  assign rd_addr     = rd_addr_q;
  assign rd_en       = rd_en_q;
  assign q_vec_valid = q_vec_valid_q;
  assign q_vec       = q_vec_valid_q ? merged : '0;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = {LANES{wr_q_q}};
  assign wr_be       = wr_be_q;

endmodule

// File: tb/tb_q_mem_if.sv
// Directed bench for q_mem_if with default parameters; expected values are worked out by hand.
module tb_q_mem_if;

  logic        clk;
  logic        rst;
  logic        rd_valid;
  logic [11:0] rd_state;
  logic [31:0] rd_addr;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        q_vec_valid;
  logic [63:0] q_vec;
  logic        wr_valid;
  logic [11:0] wr_state;
  logic [1:0]  wr_act;
  logic [15:0] wr_q;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        act_valid;
  logic [1:0]  act_in;
  logic        act_dly_valid;
  logic [1:0]  act_dly;

  int checks;
  int failures;

  q_mem_if dut (
    .clk          (clk),
    .rst          (rst),
    .rd_valid     (rd_valid),
    .rd_state     (rd_state),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .q_vec_valid  (q_vec_valid),
    .q_vec        (q_vec),
    .wr_valid     (wr_valid),
    .wr_state     (wr_state),
    .wr_act       (wr_act),
    .wr_q         (wr_q),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .act_valid    (act_valid),
    .act_in       (act_in),
    .act_dly_valid(act_dly_valid),
    .act_dly      (act_dly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] expVec;
  logic        expValid;
  logic [1:0]  expAct;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    rd_valid  = 1'b0;
    rd_state  = '0;
    rd_data   = '0;
    wr_valid  = 1'b0;
    wr_state  = '0;
    wr_act    = '0;
    wr_q      = '0;
    act_valid = 1'b0;
    act_in    = '0;

    // Reset state
    #12;
    checkOutput("reset rd_en", 64'(rd_en), 64'd0);
    checkOutput("reset rd_addr", 64'(rd_addr), 64'd0);
    checkOutput("reset wr_be", 64'(wr_be), 64'd0);
    checkOutput("reset q_vec_valid", 64'(q_vec_valid), 64'd0);
    checkOutput("reset act_dly_valid", 64'(act_dly_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Read state 3: address 0x18, q_vec two edges after the request
    @(negedge clk);
    rd_valid = 1'b1;
    rd_state = 12'd3;
    stepEdge();
    checkOutput("rd3 rd_en", 64'(rd_en), 64'd1);
    checkOutput("rd3 rd_addr", 64'(rd_addr), 64'h18);
    checkOutput("rd3 early q_vec_valid", 64'(q_vec_valid), 64'd0);
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data  = 64'h0004_0003_0002_0001;
    stepEdge();
    checkOutput("rd3 q_vec_valid", 64'(q_vec_valid), 64'd1);
    checkOutput("rd3 lane2", 64'(q_vec[47:32]), 64'h0003);
    checkOutput("rd3 q_vec", q_vec, 64'h0004_0003_0002_0001);
    checkOutput("rd3 rd_en drop", 64'(rd_en), 64'd0);
    checkOutput("rd3 rd_addr hold", 64'(rd_addr), 64'h18);
    stepEdge();
    checkOutput("rd3 valid pulse", 64'(q_vec_valid), 64'd0);

    // Write state 5 lane 2
    @(negedge clk);
    wr_valid = 1'b1;
    wr_state = 12'd5;
    wr_act   = 2'd2;
    wr_q     = 16'hBEEF;
    stepEdge();
    checkOutput("wr5 wr_addr", 64'(wr_addr), 64'h28);
    checkOutput("wr5 wr_be", 64'(wr_be), 64'h30);
    checkOutput("wr5 wr_data", wr_data, 64'hBEEF_BEEF_BEEF_BEEF);
    @(negedge clk);
    wr_valid = 1'b0;
    stepEdge();
    checkOutput("wr idle wr_be", 64'(wr_be), 64'd0);

    // Back-to-back reads of states 1 and 2
    @(negedge clk);
    rd_valid = 1'b1;
    rd_state = 12'd1;
    stepEdge();
    checkOutput("b2b first rd_addr", 64'(rd_addr), 64'h08);
    @(negedge clk);
    rd_state = 12'd2;
    rd_data  = 64'h1111_1111_1111_1111;
    stepEdge();
    checkOutput("b2b second rd_addr", 64'(rd_addr), 64'h10);
    checkOutput("b2b second rd_en", 64'(rd_en), 64'd1);
    checkOutput("b2b first q_vec", q_vec, 64'h1111_1111_1111_1111);
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data  = 64'h2222_2222_2222_2222;
    stepEdge();
    checkOutput("b2b second q_vec_valid", 64'(q_vec_valid), 64'd1);
    checkOutput("b2b second q_vec", q_vec, 64'h2222_2222_2222_2222);

    // Read state 7, write state 7 lane 1 in the return cycle
    @(negedge clk);
    rd_valid = 1'b1;
    rd_state = 12'd7;
    stepEdge();
    @(negedge clk);
    rd_valid = 1'b0;
    wr_valid = 1'b1;
    wr_state = 12'd7;
    wr_act   = 2'd1;
    wr_q     = 16'h1234;
    rd_data  = 64'h4444_3333_2222_1111;
    stepEdge();
`ifdef Q_BYPASS_EN
    expVec = 64'h4444_3333_1234_1111;
`else
    expVec = 64'h4444_3333_2222_1111;
`endif
    checkOutput("late bypass q_vec", q_vec, expVec);
    @(negedge clk);
    wr_valid = 1'b0;

    // Two writes to state 7 lane 0 across both bypass cycles: the later one wins
    @(negedge clk);
    rd_valid = 1'b1;
    rd_state = 12'd7;
    wr_valid = 1'b1;
    wr_state = 12'd7;
    wr_act   = 2'd0;
    wr_q     = 16'h0001;
    stepEdge();
    @(negedge clk);
    rd_valid = 1'b0;
    wr_q     = 16'h0002;
    rd_data  = 64'h5555_6666_7777_8888;
    stepEdge();
`ifdef Q_BYPASS_EN
    expVec = 64'h5555_6666_7777_0002;
`else
    expVec = 64'h5555_6666_7777_8888;
`endif
    checkOutput("double write lane0", q_vec, expVec);

    // Early write to state 7 lane 3, then a write to state 8 that must be ignored
    @(negedge clk);
    rd_valid = 1'b1;
    rd_state = 12'd7;
    wr_valid = 1'b1;
    wr_state = 12'd7;
    wr_act   = 2'd3;
    wr_q     = 16'h0009;
    stepEdge();
    @(negedge clk);
    rd_valid = 1'b0;
    wr_state = 12'd8;
    wr_q     = 16'hAAAA;
    rd_data  = 64'h1111_2222_3333_4444;
    stepEdge();
`ifdef Q_BYPASS_EN
    expVec = 64'h0009_2222_3333_4444;
`else
    expVec = 64'h1111_2222_3333_4444;
`endif
    checkOutput("early write lane3", q_vec, expVec);
    checkOutput("state8 wr_addr", 64'(wr_addr), 64'h40);

    // Only state 8 writes during a state 7 read
    @(negedge clk);
    rd_valid = 1'b1;
    rd_state = 12'd7;
    wr_act   = 2'd2;
    stepEdge();
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data  = 64'h9999_8888_7777_6666;
    stepEdge();
    checkOutput("other address ignored", q_vec, 64'h9999_8888_7777_6666);
    @(negedge clk);
    wr_valid = 1'b0;

    // Action delay line: 1,2,3 appear exactly six edges after entering
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      act_valid = (c <= 3);
      act_in    = (c <= 3) ? 2'(c) : 2'd0;
      stepEdge();
      expValid = (c >= 6) && (c <= 8);
      expAct   = expValid ? 2'(c - 5) : 2'd0;
      checkOutput($sformatf("act_dly_valid c%0d", c), 64'(act_dly_valid), 64'(expValid));
      checkOutput($sformatf("act_dly c%0d", c), 64'(act_dly), 64'(expAct));
    end

    // Reset with a read, a write and three actions in flight
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      act_valid = 1'b1;
      act_in    = 2'(c);
      if (c == 3) begin
        rd_valid = 1'b1;
        rd_state = 12'd3;
        wr_valid = 1'b1;
        wr_state = 12'd3;
        wr_act   = 2'd0;
        wr_q     = 16'h5A5A;
        rd_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      stepEdge();
    end
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst rd_en", 64'(rd_en), 64'd0);
    checkOutput("midrst rd_addr", 64'(rd_addr), 64'd0);
    checkOutput("midrst wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("midrst wr_be", 64'(wr_be), 64'd0);
    checkOutput("midrst wr_data", wr_data, 64'd0);
    checkOutput("midrst q_vec_valid", 64'(q_vec_valid), 64'd0);
    checkOutput("midrst q_vec", q_vec, 64'd0);
    checkOutput("midrst act_dly_valid", 64'(act_dly_valid), 64'd0);
    checkOutput("midrst act_dly", 64'(act_dly), 64'd0);
    @(negedge clk);
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    act_valid = 1'b0;
    act_in    = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      stepEdge();
      checkOutput($sformatf("post-reset q_vec_valid c%0d", c), 64'(q_vec_valid), 64'd0);
      checkOutput($sformatf("post-reset act_dly_valid c%0d", c), 64'(act_dly_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
